// File: rtl/sbentsrc_reader.sv
// Entropy-source reader: warmup, repetition-count and adaptive-proportion health
// tests, Von Neumann debiasing and a byte output with ready/valid backpressure.
module sbentsrc_reader #(
    parameter int RNG_WIDTH  = 4,
    parameter int WARMUP     = 64,
    parameter int RCT_CUTOFF = 8,
    parameter int APT_LO     = 16,
    parameter int APT_HI     = 48
) (
    input  logic                 i_clk,
    input  logic                 i_reset_n,
    input  logic                 i_en,
    input  logic                 i_clear,
    input  logic [RNG_WIDTH-1:0] i_rnd,
    output logic                 o_src_en,
    output logic [7:0]           o_data,
    output logic                 o_valid,
    input  logic                 i_ready,
    output logic                 o_alarm
);

    localparam int WW  = $clog2(WARMUP + 1);
    localparam int RCW = $clog2(RCT_CUTOFF + 1);

    typedef enum logic [1:0] {ST_IDLE, ST_WARMUP, ST_RUN, ST_ALARM} state_t;

    state_t state_q, state_d;

    logic           sampling;
    logic           in_run;
    logic           flush;
    logic           raw_bit;

    logic [WW-1:0]  warm_cnt;
    logic           warm_done;

    logic [RNG_WIDTH-1:0] rct_prev;
    logic [RCW-1:0]       rct_cnt;
    logic [RCW-1:0]       rct_cnt_nxt;
    logic                 rct_fail;

    logic [5:0]     apt_idx;
    logic [6:0]     apt_ones;
    logic [6:0]     apt_ones_nxt;
    logic           apt_fail;
    logic           health_fail;

    logic           vn_have;
    logic           vn_first;
    logic           vn_bit_vld;

    logic [7:0]     sr;
    logic [2:0]     sr_cnt;
    logic           sr_full;
    logic [7:0]     out_data;
    logic           out_valid;
    logic           out_free;

    assign raw_bit = ^i_rnd;

    // Health tests look at the sample being taken this cycle.
    assign rct_cnt_nxt  = (rct_cnt != '0 && i_rnd == rct_prev) ? rct_cnt + RCW'(1) : RCW'(1);
    assign rct_fail     = sampling && (rct_cnt_nxt == RCW'(RCT_CUTOFF));
    assign apt_ones_nxt = apt_ones + {6'd0, raw_bit};
    assign apt_fail     = sampling && (apt_idx == 6'd63) &&
                          ((apt_ones_nxt < 7'(APT_LO)) || (apt_ones_nxt > 7'(APT_HI)));
    assign health_fail  = rct_fail | apt_fail;
    assign warm_done    = (warm_cnt == WW'(WARMUP - 1));

    // State register
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) state_q <= ST_IDLE;
        else            state_q <= state_d;
    end

    // Next-state logic; a health failure outranks disable and warmup completion
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:   if (i_en) state_d = ST_WARMUP;
            ST_WARMUP: begin
                if (health_fail)    state_d = ST_ALARM;
                else if (!i_en)     state_d = ST_IDLE;
                else if (warm_done) state_d = ST_RUN;
            end
            ST_RUN: begin
                if (health_fail) state_d = ST_ALARM;
                else if (!i_en)  state_d = ST_IDLE;
            end
            ST_ALARM:  if (i_clear) state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // State-derived controls
    always_comb begin
        sampling = 1'b0;
        in_run   = 1'b0;
        flush    = 1'b0;
        case (state_q)
            ST_WARMUP: sampling = 1'b1;
            ST_RUN: begin
                sampling = 1'b1;
                in_run   = 1'b1;
            end
            default: ;
        endcase
        if (state_d == ST_IDLE || state_d == ST_ALARM) flush = 1'b1;
    end

    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            o_src_en <= 1'b0;
            o_alarm  <= 1'b0;
        end else begin
            o_src_en <= (state_d == ST_WARMUP) || (state_d == ST_RUN);
            o_alarm  <= (state_d == ST_ALARM);
        end
    end

    // Sample-side state: warmup counter, health-test counters, VN pair
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            warm_cnt <= '0;
            rct_prev <= '0;
            rct_cnt  <= '0;
            apt_idx  <= '0;
            apt_ones <= '0;
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if (flush) begin
            warm_cnt <= '0;
            rct_prev <= '0;
            rct_cnt  <= '0;
            apt_idx  <= '0;
            apt_ones <= '0;
            vn_have  <= 1'b0;
            vn_first <= 1'b0;
        end else if (sampling) begin
            rct_prev <= i_rnd;
            rct_cnt  <= rct_cnt_nxt;
            apt_idx  <= apt_idx + 6'd1;
            apt_ones <= (apt_idx == 6'd63) ? 7'd0 : apt_ones_nxt;
            if (!in_run) warm_cnt <= warm_cnt + WW'(1);
            if (in_run) begin
                vn_have  <= ~vn_have;
                vn_first <= raw_bit;
            end
        end
    end

    // 10 -> 1, 01 -> 0: the debiased bit is the first bit of an unequal pair
    assign vn_bit_vld = in_run && vn_have && (vn_first != raw_bit);
    assign out_free   = !out_valid || i_ready;

    // Byte assembly and output register; bits arriving while a byte waits are dropped
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            sr        <= '0;
            sr_cnt    <= '0;
            sr_full   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else if (flush) begin
            sr        <= '0;
            sr_cnt    <= '0;
            sr_full   <= 1'b0;
            out_data  <= '0;
            out_valid <= 1'b0;
        end else begin
            if (out_valid && i_ready) out_valid <= 1'b0;
            if (sr_full) begin
                if (out_free) begin
                    out_data  <= sr;
                    out_valid <= 1'b1;
                    sr        <= '0;
                    sr_full   <= 1'b0;
                end
            end else if (vn_bit_vld) begin
                if (sr_cnt == 3'd7) begin
                    sr_cnt <= '0;
                    if (out_free) begin
                        out_data  <= {sr[6:0], vn_first};
                        out_valid <= 1'b1;
                        sr        <= '0;
                    end else begin
                        sr      <= {sr[6:0], vn_first};
                        sr_full <= 1'b1;
                    end
                end else begin
                    sr     <= {sr[6:0], vn_first};
                    sr_cnt <= sr_cnt + 3'd1;
                end
            end
        end
    end

    assign o_data  = out_data;
    assign o_valid = out_valid;

endmodule

// File: tb/tb_sbentsrc_reader.sv
// Bench for sbentsrc_reader: scenario tasks with a byte scoreboard queue.
module tb_sbentsrc_reader;

    logic       i_clk = 1'b0;
    logic       i_reset_n = 1'b0;
    logic       i_en = 1'b0;
    logic       i_clear = 1'b0;
    logic       i_ready = 1'b1;
    logic [3:0] i_rnd = 4'h0;
    logic       o_src_en;
    logic       o_valid;
    logic       o_alarm;
    logic [7:0] o_data;

    int n_cmp = 0;
    int n_bad = 0;
    logic [7:0] exp_q[$];
    logic [3:0] pat_aa  [4] = '{4'h1, 4'h0, 4'h0, 4'h1};
    logic [3:0] pat_apt [4] = '{4'h1, 4'h2, 4'h4, 4'h8};

    sbentsrc_reader dut (
        .i_clk     (i_clk),
        .i_reset_n (i_reset_n),
        .i_en      (i_en),
        .i_clear   (i_clear),
        .i_rnd     (i_rnd),
        .o_src_en  (o_src_en),
        .o_data    (o_data),
        .o_valid   (o_valid),
        .i_ready   (i_ready),
        .o_alarm   (o_alarm)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish (compared %0d)", n_cmp);
        $fatal(1, "timeout");
    end

    task automatic step();
        @(posedge i_clk);
        #1;
    endtask

    task automatic go_idle();
        i_en = 1'b0; i_clear = 1'b0; i_ready = 1'b1;
        step(); step();
    endtask

    task automatic enable();
        i_en = 1'b1; i_rnd = 4'h0;
        step();
    endtask

    task automatic test_reset();
        i_reset_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            i_en = 1'($urandom); i_clear = 1'($urandom);
            i_ready = 1'($urandom); i_rnd = 4'($urandom);
            step();
            n_cmp++; if (o_src_en !== 1'b0) begin n_bad++; $display("FAIL reset_src_en: got %b want 0", o_src_en); end
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", o_valid); end
            n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL reset_data: got %h want 00", o_data); end
            n_cmp++; if (o_alarm !== 1'b0) begin n_bad++; $display("FAIL reset_alarm: got %b want 0", o_alarm); end
        end
        i_en = 1'b1; i_clear = 1'b0; i_ready = 1'b1;
        i_reset_n = 1'b1;
        n_cmp++; if (o_src_en !== 1'b0) begin n_bad++; $display("FAIL release_src_en0: got %b want 0", o_src_en); end
        step();
        n_cmp++; if (o_src_en !== 1'b1) begin n_bad++; $display("FAIL release_src_en1: got %b want 1", o_src_en); end
        go_idle();
    endtask

    task automatic test_debias();
        logic [7:0] e;
        enable();
        for (int k = 0; k < 130; k++) begin
            i_rnd = pat_aa[k % 4]; i_ready = 1'b1;
            n_cmp++;
            if (o_valid !== (k >= 80 && k % 16 == 0)) begin
                n_bad++; $display("FAIL debias_valid k=%0d: got %b want %b", k, o_valid, (k >= 80 && k % 16 == 0));
            end
            n_cmp++; if (o_alarm !== 1'b0) begin n_bad++; $display("FAIL debias_alarm k=%0d: got %b want 0", k, o_alarm); end
            if (o_valid && i_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL debias_extra: unexpected byte %h", o_data); end
                else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) begin n_bad++; $display("FAIL debias_data: got %h want %h", o_data, e); end
                end
            end
            if (k >= 64 && (k - 64) % 16 == 15) exp_q.push_back(8'hAA);
            step();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL debias_missing: %0d bytes outstanding want 0", exp_q.size()); end
        exp_q.delete();
        go_idle();
    endtask

    task automatic test_backpressure();
        logic [7:0] e;
        int taken = 0;
        enable();
        for (int k = 0; k < 126; k++) begin
            i_rnd = pat_aa[k % 4]; i_ready = (k >= 120);
            n_cmp++;
            if (o_valid !== (k >= 80 && k <= 121)) begin
                n_bad++; $display("FAIL bp_valid k=%0d: got %b want %b", k, o_valid, (k >= 80 && k <= 121));
            end
            if (k > 80 && k < 120) begin
                n_cmp++; if (o_data !== 8'hAA) begin n_bad++; $display("FAIL bp_hold k=%0d: got %h want aa", k, o_data); end
            end
            if (o_valid && i_ready) begin
                n_cmp++; taken++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL bp_extra: unexpected byte %h", o_data); end
                else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) begin n_bad++; $display("FAIL bp_data: got %h want %h", o_data, e); end
                end
            end
            if (k == 79 || k == 95) exp_q.push_back(8'hAA);
            step();
        end
        n_cmp++; if (taken != 2) begin n_bad++; $display("FAIL bp_count: got %0d bytes want 2", taken); end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL bp_missing: %0d bytes outstanding want 0", exp_q.size()); end
        exp_q.delete();
        go_idle();
    endtask

    task automatic test_rct();
        enable();
        for (int k = 0; k < 11; k++) begin
            i_rnd = 4'h5; i_ready = 1'b1;
            n_cmp++; if (o_alarm !== (k >= 8)) begin n_bad++; $display("FAIL rct_alarm k=%0d: got %b want %b", k, o_alarm, (k >= 8)); end
            n_cmp++; if (o_src_en !== (k < 8)) begin n_bad++; $display("FAIL rct_src_en k=%0d: got %b want %b", k, o_src_en, (k < 8)); end
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL rct_valid k=%0d: got %b want 0", k, o_valid); end
            step();
        end
        // disable must not leave ALARM
        i_en = 1'b0;
        for (int k = 0; k < 3; k++) begin
            step();
            n_cmp++; if (o_alarm !== 1'b1) begin n_bad++; $display("FAIL alarm_sticky k=%0d: got %b want 1", k, o_alarm); end
        end
    endtask

    task automatic test_recovery();
        logic [7:0] e;
        i_en = 1'b1; i_clear = 1'b1;
        step();
        i_clear = 1'b0;
        n_cmp++; if (o_alarm !== 1'b0) begin n_bad++; $display("FAIL rec_alarm: got %b want 0", o_alarm); end
        n_cmp++; if (o_src_en !== 1'b0) begin n_bad++; $display("FAIL rec_idle_src_en: got %b want 0", o_src_en); end
        step();
        n_cmp++; if (o_src_en !== 1'b1) begin n_bad++; $display("FAIL rec_warm_src_en: got %b want 1", o_src_en); end
        for (int k = 0; k < 81; k++) begin
            i_rnd = pat_aa[k % 4]; i_ready = 1'b1;
            n_cmp++; if (o_valid !== (k == 80)) begin n_bad++; $display("FAIL rec_valid k=%0d: got %b want %b", k, o_valid, (k == 80)); end
            if (o_valid && i_ready) begin
                n_cmp++;
                if (exp_q.size() == 0) begin n_bad++; $display("FAIL rec_extra: unexpected byte %h", o_data); end
                else begin
                    e = exp_q.pop_front();
                    if (o_data !== e) begin n_bad++; $display("FAIL rec_data: got %h want %h", o_data, e); end
                end
            end
            if (k == 79) exp_q.push_back(8'hAA);
            step();
        end
        n_cmp++; if (exp_q.size() != 0) begin n_bad++; $display("FAIL rec_missing: %0d bytes outstanding want 0", exp_q.size()); end
        exp_q.delete();
        go_idle();
    endtask

    task automatic test_apt();
        enable();
        for (int k = 0; k < 67; k++) begin
            i_rnd = pat_apt[k % 4]; i_ready = 1'b1;
            n_cmp++; if (o_alarm !== (k >= 64)) begin n_bad++; $display("FAIL apt_alarm k=%0d: got %b want %b", k, o_alarm, (k >= 64)); end
            n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL apt_valid k=%0d: got %b want 0", k, o_valid); end
            step();
        end
    endtask

    task automatic test_reset_midop();
        i_reset_n = 1'b0; step();
        i_reset_n = 1'b1; go_idle();
        enable();
        for (int k = 0; k < 85; k++) begin
            i_rnd = pat_aa[k % 4]; i_ready = 1'b0;
            step();
        end
        n_cmp++; if (o_valid !== 1'b1) begin n_bad++; $display("FAIL midop_pending: got %b want 1", o_valid); end
        #2 i_reset_n = 1'b0;
        #1;
        n_cmp++; if (o_valid !== 1'b0) begin n_bad++; $display("FAIL midop_valid: got %b want 0", o_valid); end
        n_cmp++; if (o_data !== 8'h00) begin n_bad++; $display("FAIL midop_data: got %h want 00", o_data); end
        n_cmp++; if (o_src_en !== 1'b0) begin n_bad++; $display("FAIL midop_src_en: got %b want 0", o_src_en); end
        step();
        i_reset_n = 1'b1; i_en = 1'b0; i_ready = 1'b1;
        step();
    endtask

    initial begin
        test_reset();
        test_debias();
        test_backpressure();
        test_rct();
        test_recovery();
        test_apt();
        test_reset_midop();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
